// File: rtl/edabk_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : edabk_tx_scheduler
// Brief   : Round-robin owner selection for one shared edabk_transmitter,
//           with finish watchdog and enforced inter-frame gap (bclk domain).
// Rev     : 1.0  initial release
// ============================================================================
module edabk_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          bclk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_parity,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          timeout_err,
  output logic                          busy,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_parity,
  input  logic                          tx_finish
);

  localparam int c_IW = $clog2(NUM_REQ);
  localparam int c_CW = $clog2(TIMEOUT_CYCLES);
  localparam int c_GW = $clog2(GAP_CYCLES + 2);

  localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NUM_REQ - 1);
  localparam logic [c_IW:0]   c_NREQ     = (c_IW + 1)'(NUM_REQ);
  localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYCLES - 1);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_IW-1:0]       r_last;
  logic [c_IW-1:0]       r_win;
  logic [c_CW-1:0]       r_wcnt;
  logic [c_GW-1:0]       r_gcnt;

  logic [c_IW:0]         w_cand;
  logic [c_IW-1:0]       w_win;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_par;
  logic [NUM_REQ-1:0]    w_onehot;
  logic [c_CW-1:0]       w_wcnt_inc;

  // Search order is last+1, last+2, ... wrapping at NUM_REQ; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_last} + (c_IW + 1)'(k);
      if (w_cand >= c_NREQ) begin
        w_cand = w_cand - c_NREQ;
      end
      if (!w_found && req[w_cand[c_IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[c_IW-1:0];
      end
    end
  end

  always_comb begin
    w_data = '0;
    w_par  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == c_IW'(i)) begin
        w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_par  = req_parity[i];
      end
    end
  end

  assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_wcnt_inc = r_wcnt + c_CW'(1);

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= c_LAST_RST;
      r_win       <= '0;
      r_wcnt      <= '0;
      r_gcnt      <= '0;
      grant       <= '0;
      ack         <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      tx_parity   <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_START;
            r_win     <= w_win;
            grant     <= w_onehot;
            tx_data   <= w_data;
            tx_parity <= w_par;
            busy      <= 1'b1;
            tx_start  <= 1'b1;
          end
        end
        S_START: begin
          r_wcnt  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A finish arriving in the watchdog's last cycle still completes the frame.
          if (tx_finish) begin
            r_state <= S_DONE;
            ack     <= grant;
          end else if (w_wcnt_inc == c_TO_LAST) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            r_last      <= r_win;
            r_gcnt      <= '0;
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_wcnt <= w_wcnt_inc;
          end
        end
        S_DONE: begin
          grant  <= '0;
          r_last <= r_win;
          r_gcnt <= '0;
          if (GAP_CYCLES == 0) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gcnt == c_GAP_LAST) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + c_GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          grant   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_edabk_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_edabk_tx_scheduler
// Brief   : Directed table, corner sequences and random frames for
//           edabk_tx_scheduler, checked cycle by cycle against a timing model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_edabk_tx_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int GAP = 3;
  localparam int TO  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_parity = '0;
  logic            tx_finish = 1'b0;
  logic [N-1:0]    grant;
  logic [N-1:0]    ack;
  logic            timeout_err;
  logic            busy;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_parity;

  int total = 0;
  int bad   = 0;

  // reference state: previous winner and last latched frame contents
  int           m_last = N - 1;
  logic [DW-1:0] m_data = '0;
  logic          m_par  = 1'b0;

  int cyc = 0;
  int last_start = -100;
  int prev_start = -100;

  always #5 clk = ~clk;

  edabk_tx_scheduler #(
    .NUM_REQ        (N),
    .DATA_WIDTH     (DW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .bclk        (clk),
    .reset       (rst),
    .req         (req),
    .req_data    (req_data),
    .req_parity  (req_parity),
    .grant       (grant),
    .ack         (ack),
    .timeout_err (timeout_err),
    .busy        (busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_parity   (tx_parity),
    .tx_finish   (tx_finish)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_start) begin
      prev_start = last_start;
      last_start = cyc;
    end
  end

  typedef struct {
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    par;
    int              k;
    bit              drop;
    logic [N-1:0]    gnt;
    bit              ack;
  } vec_t;

  vec_t tv[15];

  function automatic logic [19:0] outs();
    return {tx_start, grant, busy, ack, timeout_err, tx_data, tx_parity};
  endfunction

  task automatic check(input string nm, input int n, input logic [19:0] got, input logic [19:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s idx=%0d got=%h exp=%h", nm, n, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  // One frame from an idle scheduler. k = edge (counted from the tx_start edge)
  // at which tx_finish is sampled high; 0 = never. Caller drives req first.
  task automatic run_frame(input int k, input bit drop, output logic [N-1:0] g0, output bit acked);
    int w, c, endc;
    logic [N-1:0]  oh;
    logic [DW-1:0] ed;
    logic          ep;
    logic [19:0]   e;
    g0    = '0;
    acked = 1'b0;
    w = pick(req, m_last);
    if (w < 0) begin
      total++;
      bad++;
      $display("FAIL frame_setup idx=0 got=no_request exp=request");
      return;
    end
    oh    = 4'(1) << w;
    ed    = req_data[w*DW +: DW];
    ep    = req_parity[w];
    acked = (k >= 2) && (k <= TO);
    c     = acked ? k : TO;
    endc  = acked ? k + 1 + GAP : TO + GAP;
    for (int n = 0; n <= endc; n++) begin
      @(negedge clk);
      if (n == 0) g0 = grant;
      e = {(n == 0),
           ((acked ? (n <= c) : (n < TO)) ? oh : 4'b0000),
           (n < endc),
           ((acked && n == c) ? oh : 4'b0000),
           (!acked && n == TO),
           ed, ep};
      check("frame", n, outs(), e);
      tx_finish = (n == k - 1);
      if (n == 0) begin
        req_data   = $urandom;
        req_parity = 4'($urandom);
      end
      if (drop && n == 1) req[w] = 1'b0;
      if (acked && n == c) req[w] = 1'b0;
    end
    tx_finish = 1'b0;
    m_last = w;
    m_data = ed;
    m_par  = ep;
  endtask

  task automatic idle(input int cycles, input bit stray);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      check("idle", n, outs(), {1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, m_data, m_par});
      tx_finish = stray && (n % 2 == 0);
    end
    tx_finish = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g;
    logic [N-1:0] saved;
    bit           a;
    int           kk;

    tv[0]  = '{4'b1111, 32'h44332211, 4'b0000, 2,  1'b0, 4'b0001, 1'b1};
    tv[1]  = '{4'b1110, 32'h88776655, 4'b0100, 2,  1'b0, 4'b0010, 1'b1};
    tv[2]  = '{4'b1100, 32'hCCBBAA99, 4'b1000, 2,  1'b0, 4'b0100, 1'b1};
    tv[3]  = '{4'b1000, 32'h10FFEEDD, 4'b1000, 2,  1'b0, 4'b1000, 1'b1};
    tv[4]  = '{4'b1001, 32'h5A00003C, 4'b0001, 3,  1'b0, 4'b0001, 1'b1};
    tv[5]  = '{4'b1000, 32'h7E000000, 4'b0000, 2,  1'b0, 4'b1000, 1'b1};
    tv[6]  = '{4'b0010, 32'h0000A500, 4'b0010, 10, 1'b0, 4'b0010, 1'b1};
    tv[7]  = '{4'b0101, 32'h00C30096, 4'b0100, 0,  1'b0, 4'b0100, 1'b0};
    tv[8]  = '{4'b0101, 32'h00C30096, 4'b0001, 2,  1'b0, 4'b0001, 1'b1};
    tv[9]  = '{4'b0100, 32'h00E10000, 4'b0000, 2,  1'b0, 4'b0100, 1'b1};
    tv[10] = '{4'b1000, 32'hF0000000, 4'b1000, TO, 1'b0, 4'b1000, 1'b1};
    tv[11] = '{4'b0001, 32'h00000081, 4'b0001, 1,  1'b0, 4'b0001, 1'b0};
    tv[12] = '{4'b0001, 32'h00000042, 4'b0000, TO + GAP, 1'b0, 4'b0001, 1'b0};
    tv[13] = '{4'b0011, 32'h00006618, 4'b0010, 5,  1'b1, 4'b0010, 1'b1};
    tv[14] = '{4'b0011, 32'h00002419, 4'b0001, 2,  1'b0, 4'b0001, 1'b1};

    @(negedge clk);
    check("reset_state", 0, outs(), 20'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(4, 1'b1);

    for (int i = 0; i < 15; i++) begin
      req        = tv[i].req;
      req_data   = tv[i].data;
      req_parity = tv[i].par;
      run_frame(tv[i].k, tv[i].drop, g, a);
      check("tbl_grant", i, 20'(g), 20'(tv[i].gnt));
      check("tbl_ack", i, 20'(a), 20'(tv[i].ack));
    end

    // two pending requests, immediate finish: start-to-start spacing
    req = 4'b0110;
    run_frame(2, 1'b0, g, a);
    run_frame(2, 1'b0, g, a);
    check("gap_spacing", 0, 20'(last_start - prev_start), 20'(4 + GAP));

    // reset while waiting for finish
    req = 4'b0100;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async", 0, outs(), 20'h0);
    @(negedge clk);
    req    = 4'b1000;
    rst    = 1'b0;
    m_last = N - 1;
    m_data = '0;
    m_par  = 1'b0;
    run_frame(4, 1'b0, g, a);
    check("reset_regrant", 0, 20'(g), 20'(4'b1000));

    for (int f = 0; f < 120; f++) begin
      req = req | 4'($urandom);
      if (req == 4'b0000) req = 4'(1 << $urandom_range(0, 3));
      req_data   = $urandom;
      req_parity = 4'($urandom);
      kk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO + GAP)) : int'($urandom_range(2, 8));
      run_frame(kk, ($urandom_range(0, 7) == 0), g, a);
      if ($urandom_range(0, 4) == 0) begin
        saved = req;
        req   = '0;
        idle(int'($urandom_range(1, 4)), 1'b1);
        req   = saved;
      end
    end

    req = '0;
    idle(3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
